fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded by reset.
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  is an asynchronous, active-high reset.
REQ-004 Port stall  input  1  SHALL hold the PC and the delivered instruction when high.
REQ-005 Port flush  input  1  SHALL invalidate the instruction fetched at the current edge.
REQ-006 Port branch_taken  input  1  SHALL redirect fetch to branch_target.
REQ-007 Port branch_target  input  32  is the redirect byte address.
REQ-008 Port im_addr  output  7  is the word address to the synchronous instruction memory, equal to pc_next[8:2].
REQ-009 Port im_data  input  32  is the instruction memory output, valid one edge after im_addr.
REQ-010 Port if_inst  output  32  is the instruction to decode: im_data when if_valid, else 32'h0 (NOP).
REQ-011 Port if_pc4  output  32  is pc+4 of the delivered instruction.
REQ-012 Port if_valid  output  1  marks if_inst as a real instruction.
REQ-013 Port fetch_count  output  32  counts delivered valid instructions.
REQ-014 Port misaligned  output  1  is a sticky flag for a taken branch_target with [1:0] != 0.

Function
REQ-015 The PC register SHALL be 32 bits; im_data at any cycle SHALL correspond to the current pc.
REQ-016 State machine states SHALL be BOOT and RUN; BOOT SHALL go to RUN on the first edge after reset deasserts, unconditionally.
REQ-017 pc_next SHALL be: BOOT -> pc; else branch_taken -> {branch_target[31:2],2'b00}; else stall -> pc; else pc+4.
REQ-018 branch_taken SHALL take priority over stall.
REQ-019 On each edge pc SHALL load pc_next.
REQ-020 if_valid SHALL load: flush -> 0; else BOOT -> 1; else branch_taken -> 1; else stall -> hold; else 1.
REQ-021 flush SHALL take priority over every other if_valid source, including branch_taken.
REQ-022 if_pc4 SHALL be pc+4, combinational from pc.
REQ-023 The PC SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); im_addr SHALL wrap 127 -> 0 at byte address 0x200 multiples.
REQ-024 fetch_count SHALL increment by 1 at each edge where if_valid is 1 and stall is 0, wrapping at 2^32.
REQ-025 misaligned SHALL set at an edge with branch_taken=1 and branch_target[1:0]!=0 and hold until reset; the low bits SHALL be dropped.
REQ-026 During stall, im_addr SHALL equal pc[8:2] so the memory re-reads the held instruction.
REQ-027 Delivery latency: an instruction at address A SHALL appear on if_inst one edge after A is driven on im_addr.

Reset
REQ-028 While reset is high: pc=RESET_PC, state=BOOT, if_valid=0, fetch_count=0, misaligned=0, if_inst=0, if_pc4=RESET_PC+4, im_addr=RESET_PC[8:2].
REQ-029 Reset asserted mid-operation SHALL force the REQ-028 values immediately, without waiting for clk.
REQ-030 The first post-reset edge SHALL fetch RESET_PC; it SHALL NOT be skipped.

Verification
REQ-031 Reset release with RESET_PC=0, mem[0..2]=A,B,C, no stall: if_inst sequence 0,A,B,C with if_pc4 4,4,8,12.
REQ-032 Stall high for 3 cycles while B is delivered: if_inst stays B, if_pc4 stays 8, fetch_count frozen, im_addr held at 1.
REQ-033 branch_taken with target 0x40 while pc=0x8, stall also high: next if_inst is mem[16], if_pc4 0x44, if_valid 1.
REQ-034 flush and branch_taken together, target 0x20: next if_valid=0 and if_inst=0; the following edge delivers mem[8].
REQ-035 branch_target 0x1FE taken: misaligned=1 and stays 1; fetch resumes at 0x1FC (mem[127]) and then im_addr wraps to 0.
REQ-036 Reset pulsed asynchronously between edges with pc=0x30: outputs show REQ-028 values before the next edge; the first instruction delivered afterwards is mem[0].

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: the instruction-memory port plus the instruction bundle
// handed to decode. The fetch stage is the master; memory and decode sit on the slave side.
interface fetch_if;
  logic [6:0]  im_addr;
  logic [31:0] im_data;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;

  modport master (
    output im_addr,
    input  im_data,
    output if_inst,
    output if_pc4,
    output if_valid
  );

  modport slave (
    input  im_addr,
    output im_data,
    input  if_inst,
    input  if_pc4,
    input  if_valid
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: PC register with branch/stall/flush control, feeding a
// synchronous instruction memory whose output always corresponds to the current pc.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  fetch_if.master     bus,
  output logic [31:0] fetch_count,
  output logic        misaligned
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        valid;
  logic        valid_next;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output gets a default first, so no path through this block infers a latch.
  always_comb begin
    state_next = RUN;
    pc_next    = pc + 32'd4;
    valid_next = 1'b1;

    if (state == BOOT) begin
      pc_next = pc;
    end else if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end

    // Flush beats everything; a stall without redirect keeps the current word's validity.
    if (flush) begin
      valid_next = 1'b0;
    end else if (state == RUN && !branch_taken && stall) begin
      valid_next = valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      valid       <= 1'b0;
      fetch_count <= 32'd0;
      misaligned  <= 1'b0;
    end else begin
      pc    <= pc_next;
      valid <= valid_next;
      if (valid && !stall) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (branch_taken && (branch_target[1:0] != 2'b00)) begin
        misaligned <= 1'b1;
      end
    end
  end

  // The memory registers im_addr, so presenting pc_next keeps im_data aligned with pc.
  assign bus.im_addr  = pc_next[8:2];
  assign bus.if_inst  = valid ? bus.im_data : 32'h0000_0000;
  assign bus.if_pc4   = pc + 32'd4;
  assign bus.if_valid = valid;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus random stimulus, with a
// rule-level reference model feeding a scoreboard queue drained by a negedge monitor.
module tb_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b1;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] fetch_count;
  logic        misaligned;

  fetch_if bus();

  fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .bus           (bus),
    .fetch_count   (fetch_count),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [128];
  always @(posedge clk) bus.im_data <= mem[bus.im_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] count;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: architectural state of the fetch stage.
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic        m_run;
  logic        m_valid;
  logic        m_mis;

  function automatic logic [31:0] model_next();
    if (!m_run)       return m_pc;
    if (branch_taken) return branch_target & ~32'h3;
    if (stall)        return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_count = 0;
    m_run   = 1'b0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    nxt = model_next();
    if (m_valid && !stall) m_count = m_count + 1;
    if (branch_taken && branch_target[1:0] != 2'b00) m_mis = 1'b1;
    if (flush) m_valid = 1'b0;
    else if (!m_run || branch_taken || !stall) m_valid = 1'b1;
    m_pc  = nxt;
    m_run = 1'b1;
  endtask

  task automatic push_expect();
    exp_t        e;
    logic [31:0] nxt;
    logic [31:0] cur;
    nxt     = model_next();
    cur     = m_pc;
    e.addr  = nxt[8:2];
    e.inst  = m_valid ? mem[cur[8:2]] : 32'h0;
    e.pc4   = m_pc + 32'd4;
    e.valid = m_valid;
    e.count = m_count;
    e.mis   = m_mis;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge: apply inputs, record expectation, take the edge.
  task automatic cycle(input logic s, input logic f, input logic b, input logic [31:0] t);
    stall         = s;
    flush         = f;
    branch_taken  = b;
    branch_target = t;
    push_expect();
    @(posedge clk);
    #1;
    if (!reset) model_edge();
  endtask

  // Asynchronous reset pulse that starts and ends between two rising edges.
  task automatic pulse_reset();
    #1;
    reset         = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    push_expect();
    #1;
    check("async_rst_valid", {31'h0, bus.if_valid}, 32'h0);
    check("async_rst_pc4", bus.if_pc4, RESET_PC + 32'd4);
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("im_addr",     {25'h0, bus.im_addr},  {25'h0, mon_e.addr});
      check("if_inst",     bus.if_inst,           mon_e.inst);
      check("if_pc4",      bus.if_pc4,            mon_e.pc4);
      check("if_valid",    {31'h0, bus.if_valid}, {31'h0, mon_e.valid});
      check("fetch_count", fetch_count,           mon_e.count);
      check("misaligned",  {31'h0, misaligned},   {31'h0, mon_e.mis});
    end
  end

  initial begin
    logic [31:0] held_count;
    for (int i = 0; i < 128; i++) mem[i] = {i[7:0], 24'($urandom)};
    reset         = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    model_reset();
    #1;

    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    reset = 1'b0;

    // Release: 0, A, B, C with pc4 4, 4, 8, 12.
    cycle(0, 0, 0, 0);
    check("rel_A_inst", bus.if_inst, mem[0]);
    check("rel_A_pc4", bus.if_pc4, 32'd4);
    cycle(0, 0, 0, 0);
    held_count = fetch_count;

    // Stall for three edges while B is on decode.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("stall_inst", bus.if_inst, mem[1]);
    check("stall_pc4", bus.if_pc4, 32'd8);
    check("stall_addr", {25'h0, bus.im_addr}, 32'd1);
    check("stall_count", fetch_count, held_count);
    cycle(0, 0, 0, 0);
    check("rel_C_inst", bus.if_inst, mem[2]);
    check("rel_C_pc4", bus.if_pc4, 32'd12);

    // Branch wins over stall.
    cycle(1, 0, 1, 32'h40);
    check("br_stall_inst", bus.if_inst, mem[16]);
    check("br_stall_pc4", bus.if_pc4, 32'h44);

    // Flush wins over branch.
    cycle(0, 1, 1, 32'h20);
    check("flush_valid", {31'h0, bus.if_valid}, 32'h0);
    check("flush_inst", bus.if_inst, 32'h0);
    cycle(0, 0, 0, 0);

    // Misaligned target, then im_addr wrap past 0x1FC.
    cycle(0, 0, 1, 32'h1FE);
    check("mis_set", {31'h0, misaligned}, 32'h1);
    check("mis_inst", bus.if_inst, mem[127]);
    cycle(0, 0, 0, 0);
    check("wrap_inst", bus.if_inst, mem[0]);
    check("mis_sticky", {31'h0, misaligned}, 32'h1);

    // 32-bit PC wrap.
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    check("pcwrap_pc4", bus.if_pc4, 32'h0);
    cycle(0, 0, 0, 0);
    check("pcwrap_after", bus.if_pc4, 32'h4);

    // Asynchronous reset with pc at 0x30.
    cycle(0, 0, 1, 32'h30);
    cycle(1, 0, 0, 0);
    pulse_reset();
    check("post_rst_inst", bus.if_inst, mem[0]);
    check("post_rst_pc4", bus.if_pc4, RESET_PC + 32'd4);
    check("post_rst_mis", {31'h0, misaligned}, 32'h0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 6) == 0, tgt);
      end
    end

    cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
